// File: rtl/mcpu_mem_ptw_arb_pkg.sv
// Shared definitions for the page-table-walker arbiter.
//   ptwarb_state_e : arbiter FSM states (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//   REQ_ITLB/DTLB  : requester ids (itlb=0, dtlb=1)
package mcpu_mem_ptw_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } ptwarb_state_e;

    localparam logic REQ_ITLB = 1'b0;
    localparam logic REQ_DTLB = 1'b1;

endpackage

// File: rtl/mcpu_mem_ptw_arb_if.sv
// Bus bundle between the two TLBs, the arbiter and the page-table walker.
//   slave  : arbiter view (TLB requests and walker results in; responses and
//            walker request out)
//   master : environment view (TLBs + walker), directions mirrored
interface mcpu_mem_ptw_arb_if;
    // TLB -> arbiter
    logic         itlb2ptwarb_re;
    logic [31:12] itlb2ptwarb_addr;
    logic [19:0]  itlb2ptwarb_pagedir_base;
    logic         dtlb2ptwarb_re;
    logic [31:12] dtlb2ptwarb_addr;
    logic [19:0]  dtlb2ptwarb_pagedir_base;
    // arbiter -> TLBs
    logic         ptwarb2itlb_valid;
    logic         ptwarb2dtlb_valid;
    logic [31:12] ptwarb2tlb_phys_addr;
    logic [3:0]   ptwarb2tlb_pagetab_flags;
    logic [3:0]   ptwarb2tlb_pagedir_flags;
    // arbiter -> walker
    logic         ptwarb2ptw_re;
    logic [31:12] ptwarb2ptw_addr;
    logic [19:0]  ptwarb2ptw_pagedir_base;
    // walker -> arbiter
    logic         ptw2ptwarb_ready;
    logic [31:12] ptw2ptwarb_phys_addr;
    logic [3:0]   ptw2ptwarb_pagetab_flags;
    logic [3:0]   ptw2ptwarb_pagedir_flags;

    modport slave (
        input  itlb2ptwarb_re, itlb2ptwarb_addr, itlb2ptwarb_pagedir_base,
        input  dtlb2ptwarb_re, dtlb2ptwarb_addr, dtlb2ptwarb_pagedir_base,
        output ptwarb2itlb_valid, ptwarb2dtlb_valid, ptwarb2tlb_phys_addr,
        output ptwarb2tlb_pagetab_flags, ptwarb2tlb_pagedir_flags,
        output ptwarb2ptw_re, ptwarb2ptw_addr, ptwarb2ptw_pagedir_base,
        input  ptw2ptwarb_ready, ptw2ptwarb_phys_addr,
        input  ptw2ptwarb_pagetab_flags, ptw2ptwarb_pagedir_flags
    );

    modport master (
        output itlb2ptwarb_re, itlb2ptwarb_addr, itlb2ptwarb_pagedir_base,
        output dtlb2ptwarb_re, dtlb2ptwarb_addr, dtlb2ptwarb_pagedir_base,
        input  ptwarb2itlb_valid, ptwarb2dtlb_valid, ptwarb2tlb_phys_addr,
        input  ptwarb2tlb_pagetab_flags, ptwarb2tlb_pagedir_flags,
        input  ptwarb2ptw_re, ptwarb2ptw_addr, ptwarb2ptw_pagedir_base,
        output ptw2ptwarb_ready, ptw2ptwarb_phys_addr,
        output ptw2ptwarb_pagetab_flags, ptw2ptwarb_pagedir_flags
    );
endinterface

// File: rtl/mcpu_mem_ptw_arb_pick.sv
// Combinational 2-way requester picker.
//   i_re[1:0]    : pending requests {dtlb, itlb}
//   i_last_grant : id granted last time (round-robin history)
//   i_fixed_prio : 1 = dtlb always wins ties, 0 = round-robin
//   o_grant      : winning requester id (only meaningful when |i_re)
module mcpu_mem_ptw_arb_pick
    import mcpu_mem_ptw_arb_pkg::*;
(
    input  logic [1:0] i_re,
    input  logic       i_last_grant,
    input  logic       i_fixed_prio,
    output logic       o_grant
);
    always_comb begin
        o_grant = REQ_ITLB;
        if (i_re == 2'b10) begin
            o_grant = REQ_DTLB;
        end else if (i_re == 2'b11) begin
            o_grant = i_fixed_prio ? REQ_DTLB : ~i_last_grant;
        end
    end
endmodule

// File: rtl/mcpu_mem_ptw_arb.sv
// Shares one page-table walker between the itlb (id 0) and dtlb (id 1).
// Latches the winning VPN / page-directory base for the whole walk, pulses
// ptwarb2ptw_re for one cycle, waits for walker ready, then returns the
// captured result with a one-cycle valid to the granted TLB.
//   ptwarb_clk, ptwarb_rst : clock, asynchronous active-high reset
//   ptwarb_flush           : clears the last-translation entry (optional)
//   bus                    : TLB/walker bundle, slave modport
// Optional feature macro PTWARB_LAST_XLATE_EN: one-entry last-translation
// register; a matching request skips the walk and responds from the entry.
module mcpu_mem_ptw_arb
    import mcpu_mem_ptw_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic              ptwarb_clk,
    input  logic              ptwarb_rst,
`ifdef PTWARB_LAST_XLATE_EN
    input  logic              ptwarb_flush,
`endif
    mcpu_mem_ptw_arb_if.slave bus
);
    ptwarb_state_e r_state, w_next;
    logic          r_grant, r_last_grant;
    logic [19:0]   r_addr, r_base, r_ppn;
    logic [3:0]    r_ptf, r_pdf;

    logic          w_win, w_start, w_capture, w_hit;
    logic [19:0]   w_win_addr, w_win_base;

    mcpu_mem_ptw_arb_pick u_pick (
        .i_re         ({bus.dtlb2ptwarb_re, bus.itlb2ptwarb_re}),
        .i_last_grant (r_last_grant),
        .i_fixed_prio (FIXED_PRIO != 0),
        .o_grant      (w_win)
    );

    assign w_win_addr = w_win ? bus.dtlb2ptwarb_addr : bus.itlb2ptwarb_addr;
    assign w_win_base = w_win ? bus.dtlb2ptwarb_pagedir_base
                              : bus.itlb2ptwarb_pagedir_base;
    // The walker may still be busy with a walk abandoned by a reset, so a new
    // grant also waits for ready.
    assign w_start    = (r_state == ST_IDLE) && bus.ptw2ptwarb_ready &&
                        (bus.itlb2ptwarb_re || bus.dtlb2ptwarb_re);
    assign w_capture  = (r_state == ST_WAIT) && bus.ptw2ptwarb_ready;

`ifdef PTWARB_LAST_XLATE_EN
    logic        r_lx_valid;
    logic [19:0] r_lx_vpn, r_lx_base, r_lx_ppn;
    logic [3:0]  r_lx_ptf, r_lx_pdf;

    assign w_hit = r_lx_valid && (r_lx_vpn == w_win_addr) &&
                   (r_lx_base == w_win_base);

    // Only fully present translations are remembered; flush beats fill.
    always_ff @(posedge ptwarb_clk or posedge ptwarb_rst) begin
        if (ptwarb_rst) begin
            r_lx_valid <= 1'b0;
            r_lx_vpn   <= '0;
            r_lx_base  <= '0;
            r_lx_ppn   <= '0;
            r_lx_ptf   <= '0;
            r_lx_pdf   <= '0;
        end else if (ptwarb_flush) begin
            r_lx_valid <= 1'b0;
        end else if (w_capture && bus.ptw2ptwarb_pagetab_flags[0] &&
                     bus.ptw2ptwarb_pagedir_flags[0]) begin
            r_lx_valid <= 1'b1;
            r_lx_vpn   <= r_addr;
            r_lx_base  <= r_base;
            r_lx_ppn   <= bus.ptw2ptwarb_phys_addr;
            r_lx_ptf   <= bus.ptw2ptwarb_pagetab_flags;
            r_lx_pdf   <= bus.ptw2ptwarb_pagedir_flags;
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    always_ff @(posedge ptwarb_clk or posedge ptwarb_rst) begin
        if (ptwarb_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start) w_next = w_hit ? ST_RESP : ST_ISSUE;
            ST_ISSUE: w_next = ST_WAIT;
            ST_WAIT:  if (bus.ptw2ptwarb_ready) w_next = ST_RESP;
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ptwarb_clk or posedge ptwarb_rst) begin
        if (ptwarb_rst) begin
            r_grant      <= REQ_ITLB;
            r_last_grant <= REQ_DTLB;
            r_addr       <= '0;
            r_base       <= '0;
            r_ppn        <= '0;
            r_ptf        <= '0;
            r_pdf        <= '0;
        end else begin
            if (w_start) begin
                r_grant      <= w_win;
                r_last_grant <= w_win;
                r_addr       <= w_win_addr;
                r_base       <= w_win_base;
`ifdef PTWARB_LAST_XLATE_EN
                if (w_hit) begin
                    r_ppn <= r_lx_ppn;
                    r_ptf <= r_lx_ptf;
                    r_pdf <= r_lx_pdf;
                end
`endif
            end
            if (w_capture) begin
                r_ppn <= bus.ptw2ptwarb_phys_addr;
                r_ptf <= bus.ptw2ptwarb_pagetab_flags;
                r_pdf <= bus.ptw2ptwarb_pagedir_flags;
            end
        end
    end

    assign bus.ptwarb2ptw_re            = (r_state == ST_ISSUE);
    assign bus.ptwarb2ptw_addr          = r_addr;
    assign bus.ptwarb2ptw_pagedir_base  = r_base;
    assign bus.ptwarb2itlb_valid        = (r_state == ST_RESP) && (r_grant == REQ_ITLB);
    assign bus.ptwarb2dtlb_valid        = (r_state == ST_RESP) && (r_grant == REQ_DTLB);
    assign bus.ptwarb2tlb_phys_addr     = r_ppn;
    assign bus.ptwarb2tlb_pagetab_flags = r_ptf;
    assign bus.ptwarb2tlb_pagedir_flags = r_pdf;
endmodule

// File: tb/tb_mcpu_mem_ptw_arb.sv
// Scoreboard bench for mcpu_mem_ptw_arb (round-robin build) plus direct
// vectors for the picker in fixed-priority mode. Stimulus pushes expected
// walker requests and TLB responses; a negedge monitor pops and compares.
// The PTWARB_LAST_XLATE_EN section runs only when that macro is defined.
module tb_mcpu_mem_ptw_arb;
    import mcpu_mem_ptw_arb_pkg::*;

    typedef struct packed {
        logic        id;
        logic [19:0] ppn;
        logic [3:0]  ptf;
        logic [3:0]  pdf;
    } resp_t;
    typedef struct packed {
        logic [19:0] addr;
        logic [19:0] base;
    } preq_t;
    typedef struct packed {
        logic [7:0]  lat;
        logic [19:0] ppn;
        logic [3:0]  ptf;
        logic [3:0]  pdf;
    } wres_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    resp_t exp_resp_q[$];
    preq_t exp_preq_q[$];
    wres_t walk_q[$];

    mcpu_mem_ptw_arb_if bus();

`ifdef PTWARB_LAST_XLATE_EN
    logic flush = 1'b0;
`endif

    mcpu_mem_ptw_arb #(.FIXED_PRIO(0)) dut (
        .ptwarb_clk   (clk),
        .ptwarb_rst   (rst),
`ifdef PTWARB_LAST_XLATE_EN
        .ptwarb_flush (flush),
`endif
        .bus          (bus)
    );

    logic [1:0] pk_re;
    logic       pk_last, pk_fixed, pk_grant;
    mcpu_mem_ptw_arb_pick u_pick_chk (
        .i_re         (pk_re),
        .i_last_grant (pk_last),
        .i_fixed_prio (pk_fixed),
        .o_grant      (pk_grant)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_walk(input logic id, input logic [19:0] a, input logic [19:0] b,
                               input int lat, input logic [19:0] ppn,
                               input logic [3:0] ptf, input logic [3:0] pdf);
        exp_preq_q.push_back('{addr: a, base: b});
        walk_q.push_back('{lat: 8'(lat), ppn: ppn, ptf: ptf, pdf: pdf});
        exp_resp_q.push_back('{id: id, ppn: ppn, ptf: ptf, pdf: pdf});
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Returns the number of negedges from the call until the requested valid.
    task automatic wait_valid(input string nm, input logic id, input int budget, output int cyc);
        cyc = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            #1;
            if ((id ? bus.ptwarb2dtlb_valid : bus.ptwarb2itlb_valid) === 1'b1) begin
                cyc = k;
                break;
            end
        end
        if (cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no valid, expected valid within %0d cycles", nm, budget);
        end
    endtask

    task automatic itlb_req(input logic [19:0] a, input logic [19:0] b);
        bus.itlb2ptwarb_re = 1'b1;
        bus.itlb2ptwarb_addr = a;
        bus.itlb2ptwarb_pagedir_base = b;
    endtask

    // Walker model: on a request, ready drops, stays low lat cycles, then
    // rises with the next queued result. Not affected by the arbiter reset.
    initial begin
        wres_t w;
        bus.ptw2ptwarb_ready = 1'b1;
        bus.ptw2ptwarb_phys_addr = '0;
        bus.ptw2ptwarb_pagetab_flags = '0;
        bus.ptw2ptwarb_pagedir_flags = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.ptwarb2ptw_re === 1'b1) begin
                if (walk_q.size() == 0) begin
                    chk("walker_result_available", 0, 1);
                    w = '0;
                end else begin
                    w = walk_q.pop_front();
                end
                bus.ptw2ptwarb_ready = 1'b0;
                for (int k = 0; k < int'(w.lat); k++) begin
                    @(posedge clk);
                    #1;
                    if (bus.ptwarb2ptw_re !== 1'b0) chk("ptw_re_while_busy", bus.ptwarb2ptw_re, 0);
                end
                bus.ptw2ptwarb_phys_addr = w.ppn;
                bus.ptw2ptwarb_pagetab_flags = w.ptf;
                bus.ptw2ptwarb_pagedir_flags = w.pdf;
                bus.ptw2ptwarb_ready = 1'b1;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic  in_walk, prev_re, prev_v;
        preq_t hold, ep;
        resp_t er;
        in_walk = 1'b0;
        prev_re = 1'b0;
        prev_v  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_walk = 1'b0;
                prev_re = 1'b0;
                prev_v  = 1'b0;
            end else begin
                if (bus.ptwarb2ptw_re === 1'b1) begin
                    chk("ptw_re_single_cycle", prev_re, 0);
                    if (exp_preq_q.size() == 0) begin
                        chk("ptw_re_expected", 1, 0);
                    end else begin
                        ep = exp_preq_q.pop_front();
                        chk("ptw_addr", bus.ptwarb2ptw_addr, ep.addr);
                        chk("ptw_base", bus.ptwarb2ptw_pagedir_base, ep.base);
                    end
                    hold = '{addr: bus.ptwarb2ptw_addr, base: bus.ptwarb2ptw_pagedir_base};
                    in_walk = 1'b1;
                end else if (in_walk) begin
                    chk("ptw_addr_held", bus.ptwarb2ptw_addr, hold.addr);
                    chk("ptw_base_held", bus.ptwarb2ptw_pagedir_base, hold.base);
                end
                prev_re = bus.ptwarb2ptw_re;
                if (bus.ptwarb2itlb_valid && bus.ptwarb2dtlb_valid) chk("both_valid", 1, 0);
                if (bus.ptwarb2itlb_valid || bus.ptwarb2dtlb_valid) begin
                    chk("valid_single_cycle", prev_v, 0);
                    in_walk = 1'b0;
                    if (exp_resp_q.size() == 0) begin
                        chk("resp_expected", 1, 0);
                    end else begin
                        er = exp_resp_q.pop_front();
                        chk("resp_id", bus.ptwarb2dtlb_valid, er.id);
                        chk("resp_ppn", bus.ptwarb2tlb_phys_addr, er.ppn);
                        chk("resp_pt_flags", bus.ptwarb2tlb_pagetab_flags, er.ptf);
                        chk("resp_pd_flags", bus.ptwarb2tlb_pagedir_flags, er.pdf);
                    end
                end
                prev_v = bus.ptwarb2itlb_valid || bus.ptwarb2dtlb_valid;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    // Stimulus.
    initial begin
        int cyc;
        logic [1:0]  pv_re   [6] = '{2'b11, 2'b11, 2'b01, 2'b10, 2'b11, 2'b11};
        logic        pv_last [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        pv_fix  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        pv_exp  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        bus.itlb2ptwarb_re = 1'b0;
        bus.itlb2ptwarb_addr = '0;
        bus.itlb2ptwarb_pagedir_base = '0;
        bus.dtlb2ptwarb_re = 1'b0;
        bus.dtlb2ptwarb_addr = '0;
        bus.dtlb2ptwarb_pagedir_base = '0;

        // Picker vectors (fixed priority and round-robin ties).
        for (int i = 0; i < 6; i++) begin
            pk_re = pv_re[i];
            pk_last = pv_last[i];
            pk_fixed = pv_fix[i];
            #1;
            chk($sformatf("pick_vec%0d", i), pk_grant, pv_exp[i]);
        end

        tick(3);
        chk("rst_ptw_re", bus.ptwarb2ptw_re, 0);
        chk("rst_itlb_valid", bus.ptwarb2itlb_valid, 0);
        chk("rst_dtlb_valid", bus.ptwarb2dtlb_valid, 0);
        chk("rst_ptw_addr", bus.ptwarb2ptw_addr, 0);
        chk("rst_ptw_base", bus.ptwarb2ptw_pagedir_base, 0);
        chk("rst_phys", bus.ptwarb2tlb_phys_addr, 0);
        rst = 1'b0;
        tick(2);

        // Both held from reset: itlb first, then strict alternation.
        expect_walk(REQ_ITLB, 20'h11111, 20'h22222, 2, 20'h0A001, 4'h2, 4'h1);
        expect_walk(REQ_DTLB, 20'h33333, 20'h44444, 2, 20'h0A002, 4'h2, 4'h1);
        expect_walk(REQ_ITLB, 20'h11111, 20'h22222, 2, 20'h0A003, 4'h2, 4'h1);
        expect_walk(REQ_DTLB, 20'h33333, 20'h44444, 2, 20'h0A004, 4'h2, 4'h1);
        itlb_req(20'h11111, 20'h22222);
        bus.dtlb2ptwarb_re = 1'b1;
        bus.dtlb2ptwarb_addr = 20'h33333;
        bus.dtlb2ptwarb_pagedir_base = 20'h44444;
        for (int n = 0; n < 4; n++) wait_valid("rr_alt", n[0], 40, cyc);
        bus.itlb2ptwarb_re = 1'b0;
        bus.dtlb2ptwarb_re = 1'b0;
        tick(3);

        // Single itlb walk, 6-cycle walker.
        expect_walk(REQ_ITLB, 20'h12345, 20'hABCDE, 6, 20'h00F00, 4'h3, 4'h1);
        itlb_req(20'h12345, 20'hABCDE);
        wait_valid("single", REQ_ITLB, 40, cyc);
        bus.itlb2ptwarb_re = 1'b0;
        chk("single_latency", cyc, 8);
        tick(3);

        // dtlb retargets its request while the itlb walk is in flight.
        expect_walk(REQ_ITLB, 20'h55555, 20'h66666, 5, 20'h01234, 4'h1, 4'h1);
        expect_walk(REQ_DTLB, 20'h99999, 20'hAAAAA, 2, 20'h0BEEF, 4'h5, 4'h1);
        itlb_req(20'h55555, 20'h66666);
        fork
            begin
                int c1;
                wait_valid("retarget_i", REQ_ITLB, 40, c1);
                bus.itlb2ptwarb_re = 1'b0;
            end
            begin
                int c2;
                tick(3);
                bus.dtlb2ptwarb_re = 1'b1;
                bus.dtlb2ptwarb_addr = 20'h77777;
                bus.dtlb2ptwarb_pagedir_base = 20'h88888;
                tick(2);
                bus.dtlb2ptwarb_addr = 20'h99999;
                bus.dtlb2ptwarb_pagedir_base = 20'hAAAAA;
                wait_valid("retarget_d", REQ_DTLB, 40, c2);
                bus.dtlb2ptwarb_re = 1'b0;
            end
        join
        tick(3);

        // Non-present result forwarded unchanged; a repeat walks again.
        for (int r = 0; r < 2; r++) begin
            expect_walk(REQ_ITLB, 20'h0ABCD, 20'h0DCBA, 3, 20'h00000, 4'h0, 4'h0);
            itlb_req(20'h0ABCD, 20'h0DCBA);
            wait_valid("fault", REQ_ITLB, 40, cyc);
            bus.itlb2ptwarb_re = 1'b0;
            chk("fault_latency", cyc, 5);
            tick(3);
        end

        // Reset during WAIT: stale walk result must never be returned.
        exp_preq_q.push_back('{addr: 20'h13579, base: 20'h2468A});
        walk_q.push_back('{lat: 8'd6, ppn: 20'h0AAAA, ptf: 4'h7, pdf: 4'h1});
        itlb_req(20'h13579, 20'h2468A);
        tick(3);
        rst = 1'b1;
        #1;
        chk("midrst_ptw_re", bus.ptwarb2ptw_re, 0);
        chk("midrst_itlb_valid", bus.ptwarb2itlb_valid, 0);
        chk("midrst_dtlb_valid", bus.ptwarb2dtlb_valid, 0);
        expect_walk(REQ_ITLB, 20'h13579, 20'h2468A, 2, 20'h0BBBB, 4'h3, 4'h3);
        tick(1);
        rst = 1'b0;
        wait_valid("midrst", REQ_ITLB, 40, cyc);
        bus.itlb2ptwarb_re = 1'b0;
        tick(3);

`ifdef PTWARB_LAST_XLATE_EN
        expect_walk(REQ_ITLB, 20'h0F0F0, 20'h0E0E0, 3, 20'h01111, 4'h1, 4'h1);
        itlb_req(20'h0F0F0, 20'h0E0E0);
        wait_valid("lx_fill", REQ_ITLB, 40, cyc);
        bus.itlb2ptwarb_re = 1'b0;
        tick(3);
        exp_resp_q.push_back('{id: REQ_ITLB, ppn: 20'h01111, ptf: 4'h1, pdf: 4'h1});
        itlb_req(20'h0F0F0, 20'h0E0E0);
        wait_valid("lx_hit", REQ_ITLB, 40, cyc);
        bus.itlb2ptwarb_re = 1'b0;
        chk("lx_hit_latency", cyc, 1);
        tick(3);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(1);
        expect_walk(REQ_ITLB, 20'h0F0F0, 20'h0E0E0, 3, 20'h01111, 4'h1, 4'h1);
        itlb_req(20'h0F0F0, 20'h0E0E0);
        wait_valid("lx_flushed", REQ_ITLB, 40, cyc);
        bus.itlb2ptwarb_re = 1'b0;
        chk("lx_flushed_latency", cyc, 5);
        tick(3);
`endif

        tick(5);
        chk("left_resp", exp_resp_q.size(), 0);
        chk("left_preq", exp_preq_q.size(), 0);
        chk("left_walk", walk_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mcpu_mem_ptw_arb.md
Name: mcpu_mem_ptw_arb

Overview:
Shares the single page-table walker between the instruction TLB (requester 0) and the data TLB (requester 1). It arbitrates pending misses and holds the winning VPN and page-directory base stable for the entire walk, because the walker reads them combinationally throughout. It sequences the walker's re/ready handshake and returns the walker's result to the granted TLB with a one-cycle valid pulse.

Parameters:
FIXED_PRIO, 0, 0 = round-robin between requesters; 1 = requester 1 (dtlb) always wins ties.

Ports:
ptwarb_clk  in  1  clock
ptwarb_rst  in  1  reset, asynchronous, active-high
itlb2ptwarb_re  in  1  itlb miss request (level, held until response)
itlb2ptwarb_addr  in  [31:12]  itlb virtual page number
itlb2ptwarb_pagedir_base  in  [19:0]  itlb page-directory base
dtlb2ptwarb_re  in  1  dtlb miss request
dtlb2ptwarb_addr  in  [31:12]  dtlb virtual page number
dtlb2ptwarb_pagedir_base  in  [19:0]  dtlb page-directory base
ptwarb2itlb_valid  out  1  one-cycle response pulse to itlb
ptwarb2dtlb_valid  out  1  one-cycle response pulse to dtlb
ptwarb2tlb_phys_addr  out  [31:12]  result PPN, shared bus, qualified by valids
ptwarb2tlb_pagetab_flags  out  [3:0]  PTE flags, shared
ptwarb2tlb_pagedir_flags  out  [3:0]  PDE flags, shared
ptwarb2ptw_re  out  1  walker request
ptwarb2ptw_addr  out  [31:12]  latched VPN
ptwarb2ptw_pagedir_base  out  [19:0]  latched pagedir base
ptw2ptwarb_ready  in  1  walker idle
ptw2ptwarb_phys_addr  in  [31:12]  walker result PPN
ptw2ptwarb_pagetab_flags  in  [3:0]  walker PTE flags
ptw2ptwarb_pagedir_flags  in  [3:0]  walker PDE flags

Behaviour:
- Reset values: all valids 0, ptwarb2ptw_re 0, latched addr/base/result 0, state IDLE, last_grant = 1 (itlb wins the first tie).
- All outputs are registered or decoded from state only. No input-to-output combinational paths.
- IDLE: proceed only if ptw2ptwarb_ready=1 and any re is high. Pick the winner: sole requester, or on a tie per FIXED_PRIO (RR grants the requester not equal to last_grant). Latch winner id, addr and pagedir_base; update last_grant; go to ISSUE.
- ISSUE: ptwarb2ptw_re=1 for exactly one cycle with the latched addr/base; go to WAIT.
- WAIT: re=0; addr/base held. When ptw2ptwarb_ready=1, capture phys_addr and both flag fields, then go to RESP. Walker ready is low on the first WAIT cycle by walker contract.
- RESP: assert the granted requester's valid for one cycle; shared result bus shows the captured values; go to IDLE.
- Latency: valid rises 1 cycle after walker ready returns high. Best case from re high in IDLE is IDLE + ISSUE + WAIT(n) + RESP.
- Faults (PDE or PTE present bit = 0) are forwarded unchanged. The arbiter does not interpret flags.
- Requester contract: deassert re in the cycle after its valid. re still high in IDLE after a response counts as a new request.
- Re dropped mid-walk: protocol violation. The walk completes and valid still pulses; the requester ignores it.
- Requester inputs are ignored outside IDLE. addr/base changes mid-walk have no effect.
- Reset mid-walk: returns to IDLE immediately and re drops. The walker is not reset, so IDLE waits for ptw2ptwarb_ready=1 before issuing, and the stale walk result is never returned.

Optional Feature:
Macro PTWARB_LAST_XLATE_EN.
- Defined: adds a one-entry last-translation register {valid, vpn, pagedir_base, ppn, flags}. It is filled in WAIT→RESP only when both present bits (flags[0]) are 1.
- In IDLE, a winner whose vpn and pagedir_base both match skips ISSUE/WAIT and goes directly to RESP with the stored result (2-cycle response).
- Adds port ptwarb_flush (in, 1), which clears the entry's valid the next cycle. A flush in the same cycle as a fill wins.
- Undefined: no entry, no flush port, every request walks.

Decomposition:
- Shared header MCPU_MEM_ptwarb.vh: state encodings (IDLE=0, ISSUE=1, WAIT=2, RESP=3; 2 bits), requester ids (REQ_ITLB=0, REQ_DTLB=1).
- One sub-module, mcpu_mem_ptw_arb_pick: combinational 2-way picker, inputs {re[1:0], last_grant, FIXED_PRIO}, output grant id.

Test Plan:
- Single itlb request, addr=20'h12345, base=20'hABCDE, walker model holds ready low 6 cycles and returns ppn=20'h00F00, pt flags=4'h3, pd flags=4'h1 -> ptw addr/base held constant throughout walk; re high exactly 1 cycle; ptwarb2itlb_valid pulses once, 1 cycle after ready rises, bus = 00F00/3/1; dtlb valid stays 0.
- Both re high from reset, FIXED_PRIO=0 -> itlb served first, then dtlb. Repeat with both held -> strict alternation; with FIXED_PRIO=1, dtlb always wins ties.
- dtlb changes its addr during an itlb walk -> ptwarb2ptw_addr unchanged; dtlb then served with its new addr.
- Walker returns pd flags=4'h0, pt=0, ppn=0 -> forwarded unchanged; with PTWARB_LAST_XLATE_EN defined, the entry is not filled and a repeat request walks again.
- Assert ptwarb_rst during WAIT with walker ready low 3 more cycles; itlb re stays high -> re=0 and valids=0 immediately; no new ISSUE until ready=1; then a fresh walk is issued and its result returned.
- PTWARB_LAST_XLATE_EN: two identical present requests -> second response in 2 cycles with no ptw re. Assert ptwarb_flush, repeat -> full walk.
